lpc_cycle_sequencer: RTL and testbench
======================================

// Module: lpc_cycle_sequencer
// PURPOSE
// Sits between lpc_periph (LPC clock domain) and the MCU-facing register block. Captures each decoded
// LPC cycle word (TDATA on READY rising edge) into a FIFO and drains it on pop requests. Raises a
// coalesced, acknowledged interrupt to the MCU. Replaces free-running timer polling of READY/TDATA.
// PARAMETERS
// DEPTH        8   FIFO entries; power of 2, >=2
// DATA_W       32  cycle word width (matches TDATA)
// HOLDOFF_W    16  width of interrupt coalescing counter
// IRQ_THRESH   4   level (1..DEPTH) at which holdoff is cut short
// PORTS
// lpc_lclk      in   1                 LPC clock, 33 MHz; sole clock
// lpc_lreset_n  in   1                 asynchronous, active-low reset
// enable_i      in   1                 1 = capture and IRQ enabled
// cyc_ready_i   in   1                 READY from lpc_periph; rising edge = new cycle
// cyc_data_i    in   DATA_W            TDATA from lpc_periph; sampled on the same cycle as the edge
// pop_req_i     in   1                 1-cycle pop strobe, already synchronised to lpc_lclk
// holdoff_i     in   HOLDOFF_W         coalescing delay in lpc_lclk cycles
// irq_ack_i     in   1                 1-cycle interrupt acknowledge
// clr_ovf_i     in   1                 clears ovf_o and ovf_cnt_o
// pop_data_o    out  DATA_W            head entry; valid while pop_valid_o = 1
// pop_valid_o   out  1                 FIFO non-empty
// level_o       out  $clog2(DEPTH)+1   entries held, 0..DEPTH
// irq_o         out  1                 interrupt to MCU, registered
// ovf_o         out  1                 sticky: a cycle was dropped
// ovf_cnt_o     out  8                 dropped-cycle count, saturates at 255
// BEHAVIOUR
// - Reset, async on lpc_lreset_n low: FIFO empty; level_o = 0; pop_valid_o = 0; pop_data_o = 0;
//   irq_o = 0; ovf_o = 0; ovf_cnt_o = 0; ready_q = 0; FSM = IDLE. Reset mid-operation discards all entries.
// - Edge detect: push_ev = cyc_ready_i & ~ready_q & enable_i; ready_q <= cyc_ready_i every cycle.
//   An edge arriving while enable_i = 0 is lost and is not counted as an overflow.
// - Push: on push_ev in cycle N, cyc_data_i is written at the end of N.
//   level_o and pop_valid_o reflect the new entry from N+1.
// - Pop: pop_req_i with pop_valid_o = 1 advances the head at the end of the cycle.
//   pop_req_i while empty is ignored.
// - Simultaneous push and pop:
//   - When full: both are accepted; level stays DEPTH; no overflow.
//   - When empty: only the push takes effect.
// - Overflow: push_ev while full and no pop -> entry dropped, ovf_o <= 1, ovf_cnt_o += 1 (sticks at 255).
//   clr_ovf_i zeroes both. If clr_ovf_i coincides with an overflow, the result is ovf_o = 1, cnt = 1.
// - Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full = MSBs differ and the rest are equal.
// - IRQ FSM, irq_o = (state == ASSERT):
//   - IDLE: if level_o > 0 -> HOLDOFF, hcnt <= holdoff_i.
//   - HOLDOFF: if level_o == 0 -> IDLE; else if hcnt == 0 or level_o >= IRQ_THRESH -> ASSERT;
//     else hcnt <= hcnt - 1.
//   - ASSERT: hold until irq_ack_i, then -> IDLE. Draining the FIFO does not drop irq_o.
//     If data remains, IDLE re-arms on the next cycle.
//   - enable_i = 0 in any state forces IDLE (irq_o = 0 next cycle). FIFO contents are retained and
//     still poppable.
// - Latency with holdoff_i = 0: push in N -> irq_o = 1 in N+3. With holdoff_i = H: N+3+H,
//   unless the threshold is reached first.
// TESTING
// 1. Reset, enable = 1, holdoff = 0: one READY edge with data 0xA5A5_0001 -> level 1 at N+1,
//    pop_data_o = 0xA5A5_0001, irq_o = 1 at N+3.
// 2. READY held high for 10 cycles -> exactly one entry captured; level_o = 1.
// 3. 10 edges with DEPTH = 8, no pops -> level 8, ovf_o = 1, ovf_cnt_o = 2, entries 1..8 in order;
//    clr_ovf_i -> ovf_cnt_o = 0.
// 4. holdoff = 100, pushes at t = 0, 10, 20, 30 -> irq_o rises 1 cycle after the 4th entry is visible
//    (threshold), not at t = 103.
// 5. FIFO full, push edge and pop_req in the same cycle -> level stays 8, ovf_cnt_o unchanged,
//    head = entry 2.
// 6. irq_o = 1, drain all entries, then irq_ack -> irq_o = 0 and the FSM stays IDLE.
//    Assert lpc_lreset_n low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/lpc_cycle_sequencer.sv
// Captures LPC cycle words on READY rising edges into a FIFO drained by pop strobes, and raises a
// coalesced, acknowledged interrupt toward the MCU.
module lpc_cycle_sequencer #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned HOLDOFF_W  = 16,
   parameter int unsigned IRQ_THRESH = 4
) (
   input  logic                     lpc_lclk,
   input  logic                     lpc_lreset_n,
   input  logic                     enable_i,
   input  logic                     cyc_ready_i,
   input  logic [DATA_W-1:0]        cyc_data_i,
   input  logic                     pop_req_i,
   input  logic [HOLDOFF_W-1:0]     holdoff_i,
   input  logic                     irq_ack_i,
   input  logic                     clr_ovf_i,
   output logic [DATA_W-1:0]        pop_data_o,
   output logic                     pop_valid_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     irq_o,
   output logic                     ovf_o,
   output logic [7:0]               ovf_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {StIdle, StHoldoff, StAssert} irq_state_e;

   logic                 ready_q;
   logic [DATA_W-1:0]    mem_q [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic                 ovf_q, ovf_d;
   logic [7:0]           ovf_cnt_q, ovf_cnt_d;
   irq_state_e           state_q, state_d;
   logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;

   logic push_ev, pop_ev, full, empty, push_acc, overflow;

   assign push_ev  = cyc_ready_i & ~ready_q & enable_i;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ev   = pop_req_i & ~empty;
   // When full, a simultaneous pop frees the slot the push lands in.
   assign push_acc = push_ev & (~full | pop_ev);
   assign overflow = push_ev & full & ~pop_ev;

   assign level_o     = wr_ptr_q - rd_ptr_q;
   assign pop_valid_o = ~empty;
   assign pop_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign ovf_o       = ovf_q;
   assign ovf_cnt_o   = ovf_cnt_q;
   assign irq_o       = (state_q == StAssert);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;
      if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ev)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (overflow) begin
         ovf_d     = 1'b1;
         ovf_cnt_d = clr_ovf_i ? 8'd1 : ((ovf_cnt_q == 8'hFF) ? 8'hFF : ovf_cnt_q + 8'd1);
      end else if (clr_ovf_i) begin
         ovf_d     = 1'b0;
         ovf_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge lpc_lclk or negedge lpc_lreset_n) begin
      if (!lpc_lreset_n) begin
         ready_q   <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         ovf_cnt_q <= 8'd0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         ready_q   <= cyc_ready_i;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
         ovf_cnt_q <= ovf_cnt_d;
         if (push_acc) mem_q[wr_ptr_q[AW-1:0]] <= cyc_data_i;
      end
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      if (!enable_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (level_o != '0) begin
                  state_d = StHoldoff;
                  hcnt_d  = holdoff_i;
               end
            end
            StHoldoff: begin
               if (level_o == '0) begin
                  state_d = StIdle;
               end else if ((hcnt_q == '0) || (level_o >= PW'(IRQ_THRESH))) begin
                  state_d = StAssert;
               end else begin
                  hcnt_d = hcnt_q - HOLDOFF_W'(1);
               end
            end
            StAssert: begin
               // Only the acknowledge drops the interrupt; draining does not.
               if (irq_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge lpc_lclk or negedge lpc_lreset_n) begin
      if (!lpc_lreset_n) begin
         state_q <= StIdle;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
      end
   end

endmodule

// File: tb/tb_lpc_cycle_sequencer.sv
// Randomised and directed bench for lpc_cycle_sequencer against a queue-based reference model.
module tb_lpc_cycle_sequencer;

   localparam int DEPTH  = 8;
   localparam int THRESH = 4;

   logic        lpc_lclk = 1'b0;
   logic        lpc_lreset_n = 1'b0;
   logic        enable_i = 1'b0;
   logic        cyc_ready_i = 1'b0;
   logic [31:0] cyc_data_i = '0;
   logic        pop_req_i = 1'b0;
   logic [15:0] holdoff_i = '0;
   logic        irq_ack_i = 1'b0;
   logic        clr_ovf_i = 1'b0;
   logic [31:0] pop_data_o;
   logic        pop_valid_o;
   logic [3:0]  level_o;
   logic        irq_o;
   logic        ovf_o;
   logic [7:0]  ovf_cnt_o;

   lpc_cycle_sequencer #(
      .DEPTH(DEPTH), .DATA_W(32), .HOLDOFF_W(16), .IRQ_THRESH(THRESH)
   ) dut (
      .lpc_lclk(lpc_lclk), .lpc_lreset_n(lpc_lreset_n), .enable_i(enable_i),
      .cyc_ready_i(cyc_ready_i), .cyc_data_i(cyc_data_i), .pop_req_i(pop_req_i),
      .holdoff_i(holdoff_i), .irq_ack_i(irq_ack_i), .clr_ovf_i(clr_ovf_i),
      .pop_data_o(pop_data_o), .pop_valid_o(pop_valid_o), .level_o(level_o),
      .irq_o(irq_o), .ovf_o(ovf_o), .ovf_cnt_o(ovf_cnt_o)
   );

   always #5 lpc_lclk = ~lpc_lclk;

   int n_checks = 0;
   int n_errors = 0;
   bit mon_en = 1'b0;

   // Reference model: expected FIFO contents are the scoreboard queue.
   logic [31:0] exp_q[$];
   bit          m_prev, m_ovf, m_irq;
   int          m_cnt, m_wait;   // m_wait < 0: not counting down

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_prev = 0; m_ovf = 0; m_irq = 0; m_cnt = 0; m_wait = -1;
   endtask

   task automatic model_update();
      int lvl = exp_q.size();
      bit push, pop, drop;
      if (!enable_i) begin
         m_irq = 0; m_wait = -1;
      end else if (m_irq) begin
         if (irq_ack_i) m_irq = 0;
      end else if (m_wait < 0) begin
         if (lvl > 0) m_wait = int'(holdoff_i);
      end else if (lvl == 0) begin
         m_wait = -1;
      end else if (m_wait == 0 || lvl >= THRESH) begin
         m_irq = 1; m_wait = -1;
      end else begin
         m_wait--;
      end
      push = cyc_ready_i && !m_prev && enable_i;
      pop  = pop_req_i && lvl > 0;
      drop = push && lvl == DEPTH && !pop;
      if (pop) void'(exp_q.pop_front());
      if (push && !drop) exp_q.push_back(cyc_data_i);
      if (drop) begin
         m_ovf = 1;
         m_cnt = clr_ovf_i ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
      end else if (clr_ovf_i) begin
         m_ovf = 0; m_cnt = 0;
      end
      m_prev = cyc_ready_i;
   endtask

   task automatic step(input logic r, input logic [31:0] d, input logic p, input logic a,
                       input logic c);
      cyc_ready_i = r; cyc_data_i = d; pop_req_i = p; irq_ack_i = a; clr_ovf_i = c;
      @(posedge lpc_lclk);
      model_update();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic edge_push(input logic [31:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      lpc_lreset_n = 1'b0;
      #1;
      chk("rst_level", 32'(level_o), 32'd0);
      chk("rst_valid", 32'(pop_valid_o), 32'd0);
      chk("rst_data", pop_data_o, 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_ovf", 32'(ovf_o), 32'd0);
      chk("rst_ovf_cnt", 32'(ovf_cnt_o), 32'd0);
      model_reset();
      cyc_ready_i = 0; pop_req_i = 0; irq_ack_i = 0; clr_ovf_i = 0;
      @(posedge lpc_lclk);
      #1;
      lpc_lreset_n = 1'b1;
   endtask

   // Monitor: compares every visible output against the model each cycle.
   always @(negedge lpc_lclk) begin
      if (mon_en) begin
         chk("mon_level", 32'(level_o), 32'(exp_q.size()));
         chk("mon_valid", 32'(pop_valid_o), 32'(exp_q.size() > 0));
         chk("mon_data", pop_data_o, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
         chk("mon_irq", 32'(irq_o), 32'(m_irq));
         chk("mon_ovf", 32'(ovf_o), 32'(m_ovf));
         chk("mon_ovf_cnt", 32'(ovf_cnt_o), 32'(m_cnt));
      end
   end

   initial begin
      model_reset();
      #2;
      do_reset();
      mon_en = 1'b1;
      enable_i = 1'b1;
      holdoff_i = 16'd0;

      // Single edge, holdoff 0: level at N+1, irq at N+3.
      step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
      chk("t1_level", 32'(level_o), 32'd1);
      chk("t1_data", pop_data_o, 32'hA5A5_0001);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("t1_irq_early", 32'(irq_o), 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("t1_irq", 32'(irq_o), 32'd1);

      // READY held high: one capture.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("t2_level", 32'(level_o), 32'd1);
      chk("t2_data", pop_data_o, 32'd100);

      // Ten edges into eight slots, then drain in order and clear overflow.
      do_reset();
      for (int i = 1; i <= 10; i++) edge_push(32'(i));
      chk("t3_level", 32'(level_o), 32'd8);
      chk("t3_ovf", 32'(ovf_o), 32'd1);
      chk("t3_ovf_cnt", 32'(ovf_cnt_o), 32'd2);
      for (int i = 1; i <= 8; i++) begin
         chk("t3_order", pop_data_o, 32'(i));
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      chk("t3_empty", 32'(pop_valid_o), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t3_pop_empty", 32'(level_o), 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("t3_clr_cnt", 32'(ovf_cnt_o), 32'd0);
      chk("t3_clr_ovf", 32'(ovf_o), 32'd0);

      // Threshold cuts a long holdoff short.
      do_reset();
      holdoff_i = 16'd100;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 32'(200 + k), 1'b0, 1'b0, 1'b0);
         if (k < 3) idle(9);
      end
      chk("t4_level", 32'(level_o), 32'd4);
      chk("t4_irq_pre", 32'(irq_o), 32'd0);
      idle(1);
      chk("t4_irq", 32'(irq_o), 32'd1);
      holdoff_i = 16'd0;

      // Full FIFO, push and pop together.
      do_reset();
      for (int i = 1; i <= 8; i++) edge_push(32'(i));
      step(1'b1, 32'd9, 1'b1, 1'b0, 1'b0);
      chk("t5_level", 32'(level_o), 32'd8);
      chk("t5_ovf_cnt", 32'(ovf_cnt_o), 32'd0);
      chk("t5_head", pop_data_o, 32'd2);
      // Overflow coincident with clear leaves count 1; then saturate at 255.
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'd77, 1'b0, 1'b0, 1'b1);
      chk("t5_clr_ovf_cnt", 32'(ovf_cnt_o), 32'd1);
      chk("t5_clr_ovf", 32'(ovf_o), 32'd1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 260; i++) edge_push(32'(i));
      chk("t5_sat", 32'(ovf_cnt_o), 32'd255);
      // Edge while disabled is lost, not an overflow.
      enable_i = 1'b0;
      edge_push(32'd55);
      chk("t5_dis_cnt", 32'(ovf_cnt_o), 32'd255);
      chk("t5_dis_level", 32'(level_o), 32'd8);
      enable_i = 1'b1;

      // Drain under asserted irq, then acknowledge.
      do_reset();
      for (int i = 0; i < 3; i++) edge_push(32'(300 + i));
      chk("t6_irq", 32'(irq_o), 32'd1);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t6_drained_irq", 32'(irq_o), 32'd1);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("t6_ack_irq", 32'(irq_o), 32'd0);
      idle(5);
      chk("t6_stay_idle", 32'(irq_o), 32'd0);

      // Randomised traffic with a reset landing mid-burst.
      for (int n = 0; n < 3000; n++) begin
         enable_i  = ($urandom_range(0, 29) != 0);
         holdoff_i = 16'($urandom_range(0, 6));
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 9) < 3),
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0));
         if (n == 1500) begin
            enable_i = 1'b1;
            for (int i = 0; i < 6; i++) edge_push($urandom);
            #2;
            do_reset();
         end
      end

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
